uart_rx: RTL and testbench

//  Asynchronous UART receiver for the pic16f-antastic USART. It is the receive-side twin of the TSR path.
//  It oversamples UART_RXD using the rx capture strobe from the SPBRG baud generator.
//  It de-frames 8- or 9-bit frames and pushes each frame into a 2-deep RCREG FIFO, as on PIC16F.
//  It drives the RCREG/RX9D/FERR/OERR fields of RCSTA and the RCIF set strobe.

---
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/bit9/stop de-framing into a 2-entry RCREG FIFO.
// Latency: SYNC_STAGES clks of input sync; frame pushed at mid-stop, head visible 1 clk later.
// Backpressure: none on the line; push into a full FIFO drops the frame and sets sticky oerr.
module uart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       UART_RXD,
   input  logic       rx_sample_en,
   input  logic       spen,
   input  logic       cren,
   input  logic       rx9,
   input  logic       rcreg_rd_en,
   output logic [7:0] rcreg_out,
   output logic       rx9d,
   output logic       ferr,
   output logic       oerr,
   output logic       rx_busy,
   output logic       rxif_set_en
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE / 2 + 1);
   localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_BIT9, S_STOP} state_t;

   state_t                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic [2:0]             r_bit_idx, w_bit_idx_nxt;
   logic [7:0]             r_shift, w_shift_nxt;
   logic                   r_bit8, w_bit8_nxt;
   logic                   r_rx9_lat, w_rx9_lat_nxt;
   logic                   r_s0, w_s0_nxt;
   logic                   r_s1, w_s1_nxt;
   logic                   w_push, w_push_ferr, w_pop;
   logic                   w_rxs, w_maj, w_mid, w_last;
   logic [9:0]             w_push_dat;
   logic [9:0]             r_e0, r_e1;      // {ferr, bit8, data}; r_e0 is the head
   logic [1:0]             r_fcnt;
   logic                   r_oerr;

   // Input synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '1;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], UART_RXD};
   end

   assign w_rxs  = r_sync[SYNC_STAGES-1];
   assign w_mid  = (r_cnt == C_MID);
   assign w_last = (r_cnt == C_LAST);
   // third sample is the live line value at the deciding tick
   assign w_maj  = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

   // FSM state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_bit8    <= 1'b0;
         r_rx9_lat <= 1'b0;
         r_s0      <= 1'b1;
         r_s1      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_bit8    <= w_bit8_nxt;
         r_rx9_lat <= w_rx9_lat_nxt;
         r_s0      <= w_s0_nxt;
         r_s1      <= w_s1_nxt;
      end
   end

   // Next-state: everything advances only on sample ticks; disable forces IDLE at once
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_bit8_nxt    = r_bit8;
      w_rx9_lat_nxt = r_rx9_lat;
      w_s0_nxt      = r_s0;
      w_s1_nxt      = r_s1;
      w_push        = 1'b0;
      w_push_ferr   = 1'b0;
      if (!spen || !cren) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else if (rx_sample_en) begin
         if (r_state != S_IDLE) begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == C_S0) w_s0_nxt = w_rxs;
            if (r_cnt == C_S1) w_s1_nxt = w_rxs;
         end
         case (r_state)
            S_IDLE: begin
               // the detecting tick counts as tick 0 of the start bit
               if (!w_rxs && !r_oerr) begin
                  w_state_nxt = S_START;
                  w_cnt_nxt   = CW'(1);
               end
            end
            S_START: begin
               if (w_mid) begin
                  if (w_maj) begin
                     w_state_nxt = S_IDLE;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_rx9_lat_nxt = rx9;
                     w_bit8_nxt    = 1'b0;
                  end
               end
               if (w_last) begin
                  w_state_nxt   = S_DATA;
                  w_cnt_nxt     = '0;
                  w_bit_idx_nxt = '0;
               end
            end
            S_DATA: begin
               if (w_mid) w_shift_nxt = {w_maj, r_shift[7:1]};
               if (w_last) begin
                  w_cnt_nxt = '0;
                  if (r_bit_idx == 3'd7) w_state_nxt = r_rx9_lat ? S_BIT9 : S_STOP;
                  else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
            S_BIT9: begin
               if (w_mid) w_bit8_nxt = w_maj;
               if (w_last) begin
                  w_state_nxt = S_STOP;
                  w_cnt_nxt   = '0;
               end
            end
            S_STOP: begin
               // leave half a bit early so a following start edge is caught cleanly
               if (w_mid) begin
                  w_push      = 1'b1;
                  w_push_ferr = ~w_maj;
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign w_push_dat = {w_push_ferr, r_bit8, r_shift};
   assign w_pop      = rcreg_rd_en && (r_fcnt != 2'd0);

   // RCREG FIFO and sticky overrun; pop-before-push when full and both happen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_e0   <= '0;
         r_e1   <= '0;
         r_fcnt <= '0;
         r_oerr <= 1'b0;
      end else if (!spen) begin
         r_fcnt <= '0;
         r_oerr <= 1'b0;
      end else begin
         if (!cren) r_oerr <= 1'b0;
         case ({w_push, w_pop})
            2'b10: begin
               if (r_fcnt == 2'd0) begin
                  r_e0   <= w_push_dat;
                  r_fcnt <= 2'd1;
               end else if (r_fcnt == 2'd1) begin
                  r_e1   <= w_push_dat;
                  r_fcnt <= 2'd2;
               end else begin
                  r_oerr <= 1'b1;
               end
            end
            2'b01: begin
               if (r_fcnt == 2'd2) r_e0 <= r_e1;
               r_fcnt <= r_fcnt - 2'd1;
            end
            2'b11: begin
               if (r_fcnt == 2'd1) begin
                  r_e0 <= w_push_dat;
               end else begin
                  r_e0 <= r_e1;
                  r_e1 <= w_push_dat;
               end
            end
            default: ;
         endcase
      end
   end

   // head entry stays visible after the last pop; only its error flag is masked
   assign rcreg_out   = r_e0[7:0];
   assign rx9d        = r_e0[8];
   assign ferr        = r_e0[9] & (r_fcnt != 2'd0);
   assign oerr        = r_oerr;
   assign rx_busy     = (r_state != S_IDLE);
   assign rxif_set_en = (r_fcnt != 2'd0);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16 with rx_sample_en held high.
// Each bit is driven for 16 clocks; outputs are sampled 1 time unit after the rising edge.
// Observed vector: {rcreg_out, rx9d, ferr, oerr, rx_busy, rxif_set_en}.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       UART_RXD;
   logic       rx_sample_en;
   logic       spen;
   logic       cren;
   logic       rx9;
   logic       rcreg_rd_en;
   logic [7:0] rcreg_out;
   logic       rx9d;
   logic       ferr;
   logic       oerr;
   logic       rx_busy;
   logic       rxif_set_en;

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cnt = 0;

   wire [12:0] w_obs = {rcreg_out, rx9d, ferr, oerr, rx_busy, rxif_set_en};

   uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .UART_RXD     (UART_RXD),
      .rx_sample_en (rx_sample_en),
      .spen         (spen),
      .cren         (cren),
      .rx9          (rx9),
      .rcreg_rd_en  (rcreg_rd_en),
      .rcreg_out    (rcreg_out),
      .rx9d         (rx9d),
      .ferr         (ferr),
      .oerr         (oerr),
      .rx_busy      (rx_busy),
      .rxif_set_en  (rxif_set_en)
   );

   always #5 clk = ~clk;

   // counts clocks with rx_busy high so tests can tell whether a frame started
   always @(negedge clk) if (rx_busy) busy_cnt <= busy_cnt + 1;

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      UART_RXD = b;
      clocks(16);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic use9, input logic b9, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (use9) drive_bit(b9);
      drive_bit(stop);
      UART_RXD = 1'b1;
   endtask

   task automatic pop();
      rcreg_rd_en = 1'b1;
      clocks(1);
      rcreg_rd_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] exp;
      #1;
      exp = 13'h0;
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL reset_state: got %h expected %h", w_obs, exp); end
      clocks(3);
      rst = 1'b0;
      clocks(20);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      clocks(2);
      exp = {8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL pre_reset_frame: got %h expected %h", w_obs, exp); end
      // partial frame: start + 3 data bits, then reset
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      n_tests++;
      if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid_frame: got %b expected 1", rx_busy); end
      rst = 1'b1;
      UART_RXD = 1'b1;
      #2;
      exp = 13'h0;
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL reset_mid_frame: got %h expected %h", w_obs, exp); end
      clocks(2);
      rst = 1'b0;
      clocks(20);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      clocks(2);
      exp = {8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL post_reset_frame: got %h expected %h", w_obs, exp); end
      pop();
   endtask

   task automatic test_basic();
      logic [12:0] exp;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      clocks(2);
      exp = {8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL basic_a5: got %h expected %h", w_obs, exp); end
      pop();
      exp = {8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL basic_pop: got %h expected %h", w_obs, exp); end
      pop();   // read while empty must be ignored
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL empty_pop: got %h expected %h", w_obs, exp); end
   endtask

   task automatic test_rx9();
      logic [12:0] exp;
      rx9 = 1'b1;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      rx9 = 1'b0;
      clocks(2);
      exp = {8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL rx9_frame: got %h expected %h", w_obs, exp); end
      send_frame(8'h01, 1'b0, 1'b0, 1'b1);
      clocks(2);
      pop();
      exp = {8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL rx8_second_entry: got %h expected %h", w_obs, exp); end
      pop();
      exp = {8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL rx9_drain: got %h expected %h", w_obs, exp); end
   endtask

   task automatic test_ferr();
      logic [12:0] exp;
      send_frame(8'h00, 1'b0, 1'b0, 1'b0);
      clocks(30);
      exp = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL ferr_frame: got %h expected %h", w_obs, exp); end
      pop();
      exp = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL ferr_pop: got %h expected %h", w_obs, exp); end
   endtask

   task automatic test_overrun();
      logic [12:0] exp;
      int b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      send_frame(8'h33, 1'b0, 1'b0, 1'b1);
      clocks(2);
      exp = {8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL overrun_set: got %h expected %h", w_obs, exp); end
      b0 = busy_cnt;
      send_frame(8'h44, 1'b0, 1'b0, 1'b1);
      clocks(2);
      n_tests++;
      if (busy_cnt != b0) begin n_fail++; $display("FAIL overrun_blocks_start: busy clocks %0d expected 0", busy_cnt - b0); end
      pop();
      exp = {8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL overrun_second_head: got %h expected %h", w_obs, exp); end
      pop();
      exp = {8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL overrun_drained: got %h expected %h", w_obs, exp); end
      cren = 1'b0;
      clocks(1);
      cren = 1'b1;
      exp = {8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL cren_clears_oerr: got %h expected %h", w_obs, exp); end
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      clocks(2);
      exp = {8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL after_overrun_frame: got %h expected %h", w_obs, exp); end
      pop();
   endtask

   task automatic test_false_start();
      logic [12:0] exp;
      int b0;
      b0 = busy_cnt;
      UART_RXD = 1'b0;
      clocks(4);
      UART_RXD = 1'b1;
      clocks(30);
      n_tests++;
      if (busy_cnt == b0) begin n_fail++; $display("FAIL false_start_busy: busy clocks 0 expected >0"); end
      exp = {8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL false_start_idle: got %h expected %h", w_obs, exp); end
   endtask

   task automatic test_spen_flush();
      logic [12:0] exp;
      send_frame(8'h66, 1'b0, 1'b0, 1'b1);
      clocks(2);
      spen = 1'b0;
      clocks(1);
      spen = 1'b1;
      exp = {8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      n_tests++;
      if (w_obs !== exp) begin n_fail++; $display("FAIL spen_flush: got %h expected %h", w_obs, exp); end
   endtask

   initial begin
      rst          = 1'b1;
      UART_RXD     = 1'b1;
      rx_sample_en = 1'b1;
      spen         = 1'b1;
      cren         = 1'b1;
      rx9          = 1'b0;
      rcreg_rd_en  = 1'b0;
      test_reset();
      test_basic();
      test_rx9();
      test_ferr();
      test_overrun();
      test_false_start();
      test_spen_flush();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
